// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared definitions for the RV32 pipeline stages.
//   - CTRL_W and bit positions inside the packed control bundle
//   - CTRL_BUBBLE (all-zero control word) and REG_ZERO (x0 index)
//   - upd_e: per-edge update action of a pipeline register
//   - wb_hit(): WB write matches a non-x0 register index
package pipeline_pkg;

    localparam int CTRL_W         = 8;
    localparam int CTRL_REG_WRITE = 0;
    localparam int CTRL_MEM_READ  = 1;
    localparam int CTRL_MEM_WRITE = 2;
    localparam int CTRL_USES_RS1  = 3;
    localparam int CTRL_USES_RS2  = 4;
    localparam int CTRL_ALU_OP_LO = 5;
    localparam int CTRL_ALU_OP_HI = 7;

    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;
    localparam logic [4:0]        REG_ZERO    = 5'd0;

    typedef enum logic [1:0] {
        UPD_CAPTURE = 2'd0,
        UPD_HOLD    = 2'd1,
        UPD_BUBBLE  = 2'd2
    } upd_e;

    function automatic logic wb_hit(input logic       we,
                                    input logic [4:0] wr_idx,
                                    input logic [4:0] rd_idx);
        return we && (wr_idx != REG_ZERO) && (wr_idx == rd_idx);
    endfunction

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// load_use_detect: combinational load-use hazard detection.
// A load sitting in ID/EX whose destination is read by the instruction in
// IF/ID must be separated by one bubble. x0 never creates a hazard.
// Ports:
//   valid_IdEx, mem_read_IdEx, rd_IdEx : producer in ID/EX
//   valid_IfId, uses_rs1, uses_rs2,
//   rs1_IfId, rs2_IfId                 : consumer in IF/ID
//   lu                                 : hazard present this cycle
module load_use_detect (
    input  logic       valid_IdEx,
    input  logic       mem_read_IdEx,
    input  logic [4:0] rd_IdEx,
    input  logic       valid_IfId,
    input  logic       uses_rs1,
    input  logic       uses_rs2,
    input  logic [4:0] rs1_IfId,
    input  logic [4:0] rs2_IfId,
    output logic       lu
);
    import pipeline_pkg::*;

    assign lu = valid_IdEx && mem_read_IdEx && (rd_IdEx != REG_ZERO) && valid_IfId &&
                ((uses_rs1 && (rs1_IfId == rd_IdEx)) ||
                 (uses_rs2 && (rs2_IfId == rd_IdEx)));

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the 5-stage RV32 pipeline.
// Captures decoded operands/control, inserts bubbles on load-use and branch
// flush, holds while a multicycle EX op is busy, and applies the WB-to-ID
// bypass on capture plus a WB refresh of held operands.
// Ports:
//   clk, rst_n (async, active-low)
//   ID side  : valid_IfId, pc_IfId, rs1/rs2/rd_IfId, rs1/rs2_data_Id,
//              imm_Id, ctrl_Id
//   EX side  : flush_Ex, hold_Ex
//   WB side  : reg_write_MemWB, rd_MemWB, wb_data
//   outputs  : stall_Id, valid_IdEx, pc/imm/rs1_data/rs2_data_IdEx,
//              rs1/rs2/rd_IdEx, ctrl_IdEx, reg_write_IdEx, mem_read_IdEx
// Optional: define ID_EX_PERF_CNT_EN to add saturating counters
//   lu_bubble_cnt and flush_cnt.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_IfId,
    input  logic [XLEN-1:0]   pc_IfId,
    input  logic [4:0]        rs1_IfId,
    input  logic [4:0]        rs2_IfId,
    input  logic [4:0]        rd_IfId,
    input  logic [XLEN-1:0]   rs1_data_Id,
    input  logic [XLEN-1:0]   rs2_data_Id,
    input  logic [XLEN-1:0]   imm_Id,
    input  logic [CTRL_W-1:0] ctrl_Id,
    input  logic              flush_Ex,
    input  logic              hold_Ex,
    input  logic              reg_write_MemWB,
    input  logic [4:0]        rd_MemWB,
    input  logic [XLEN-1:0]   wb_data,
    output logic              stall_Id,
    output logic              valid_IdEx,
    output logic [XLEN-1:0]   pc_IdEx,
    output logic [XLEN-1:0]   imm_IdEx,
    output logic [XLEN-1:0]   rs1_data_IdEx,
    output logic [XLEN-1:0]   rs2_data_IdEx,
    output logic [4:0]        rs1_IdEx,
    output logic [4:0]        rs2_IdEx,
    output logic [4:0]        rd_IdEx,
    output logic [CTRL_W-1:0] ctrl_IdEx,
    output logic              reg_write_IdEx,
    output logic              mem_read_IdEx
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]       lu_bubble_cnt,
    output logic [31:0]       flush_cnt
`endif
);
    import pipeline_pkg::*;

    logic            lu;
    upd_e            upd;
    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;
    logic [XLEN-1:0] rs1_keep;
    logic [XLEN-1:0] rs2_keep;

    load_use_detect u_load_use_detect (
        .valid_IdEx    (valid_IdEx),
        .mem_read_IdEx (mem_read_IdEx),
        .rd_IdEx       (rd_IdEx),
        .valid_IfId    (valid_IfId),
        .uses_rs1      (ctrl_Id[CTRL_USES_RS1]),
        .uses_rs2      (ctrl_Id[CTRL_USES_RS2]),
        .rs1_IfId      (rs1_IfId),
        .rs2_IfId      (rs2_IfId),
        .lu            (lu)
    );

    assign reg_write_IdEx = ctrl_IdEx[CTRL_REG_WRITE];
    assign mem_read_IdEx  = ctrl_IdEx[CTRL_MEM_READ];

    always_comb begin
        upd      = UPD_CAPTURE;
        stall_Id = 1'b0;
        // flush > hold > load-use > capture
        if (flush_Ex)
            upd = UPD_BUBBLE;
        else if (hold_Ex)
            upd = UPD_HOLD;
        else if (lu)
            upd = UPD_BUBBLE;
        // gated by rst_n so the stall reads 0 while the stage is in reset
        stall_Id = rst_n && !flush_Ex && (hold_Ex || lu);

        // bypass on capture ignores uses_rsX: a stale operand is never captured
        rs1_fwd  = wb_hit(reg_write_MemWB, rd_MemWB, rs1_IfId) ? wb_data : rs1_data_Id;
        rs2_fwd  = wb_hit(reg_write_MemWB, rd_MemWB, rs2_IfId) ? wb_data : rs2_data_Id;
        // refresh while held so a producer retiring past WB is not lost
        rs1_keep = wb_hit(reg_write_MemWB, rd_MemWB, rs1_IdEx) ? wb_data : rs1_data_IdEx;
        rs2_keep = wb_hit(reg_write_MemWB, rd_MemWB, rs2_IdEx) ? wb_data : rs2_data_IdEx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_IdEx    <= 1'b0;
            pc_IdEx       <= '0;
            imm_IdEx      <= '0;
            rs1_data_IdEx <= '0;
            rs2_data_IdEx <= '0;
            rs1_IdEx      <= REG_ZERO;
            rs2_IdEx      <= REG_ZERO;
            rd_IdEx       <= REG_ZERO;
            ctrl_IdEx     <= CTRL_W'(CTRL_BUBBLE);
        end else begin
            case (upd)
                UPD_BUBBLE: begin
                    // bubble clears mem_read, so a load-use bubble lasts one cycle
                    valid_IdEx <= 1'b0;
                    ctrl_IdEx  <= CTRL_W'(CTRL_BUBBLE);
                    rs1_IdEx   <= REG_ZERO;
                    rs2_IdEx   <= REG_ZERO;
                    rd_IdEx    <= REG_ZERO;
                end
                UPD_HOLD: begin
                    rs1_data_IdEx <= rs1_keep;
                    rs2_data_IdEx <= rs2_keep;
                end
                default: begin
                    valid_IdEx    <= valid_IfId;
                    pc_IdEx       <= pc_IfId;
                    imm_IdEx      <= imm_Id;
                    rs1_data_IdEx <= rs1_fwd;
                    rs2_data_IdEx <= rs2_fwd;
                    rs1_IdEx      <= rs1_IfId;
                    rs2_IdEx      <= rs2_IfId;
                    rd_IdEx       <= rd_IfId;
                    ctrl_IdEx     <= valid_IfId ? ctrl_Id : CTRL_W'(CTRL_BUBBLE);
                end
            endcase
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lu_bubble_cnt <= '0;
            flush_cnt     <= '0;
        end else begin
            if (flush_Ex && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 32'd1;
            if (!flush_Ex && !hold_Ex && lu && (lu_bubble_cnt != '1))
                lu_bubble_cnt <= lu_bubble_cnt + 32'd1;
        end
    end
`endif

endmodule
